// File: rtl/mem_loader_pkg.sv
// rtl/mem_loader_pkg.sv - shared types and constants for the SRAM image loader
package mem_loader_pkg;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  state_t;

  localparam state_t ST_FETCH = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_WRITE = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_PASS  = 3'd4;

  localparam int DEF_WR_CYCLES = 2;

endpackage

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - copies an image ROM into SRAM, then passes the SRAM port to the CPU
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int    IMG_WORDS = 256,
  parameter word_t BASE_ADDR = 16'h0000,
  parameter int    WR_CYCLES = DEF_WR_CYCLES,
  parameter bit    AUTOLOAD  = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Load_req,
  output logic [15:0] Img_addr,
  input  logic [15:0] Img_data,
  input  logic [15:0] Cpu_ADDR,
  input  logic [15:0] Cpu_Data_to_SRAM,
  input  logic        Cpu_OE,
  input  logic        Cpu_WE,
  output logic [15:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  output logic        OE,
  output logic        WE,
  output logic        Cpu_hold,
  output logic        Done
);

  localparam word_t      LAST_WORD = 16'(IMG_WORDS - 1);
  localparam logic [3:0] WAIT_INIT = 4'(WR_CYCLES - 1);

  state_t     state;
  word_t      cnt;
  logic [3:0] wait_cnt;
  word_t      img_addr_q;
  word_t      addr_q;
  word_t      data_q;
  logic       we_q;
  logic       done_q;
  logic       hold_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= AUTOLOAD ? ST_FETCH : ST_PASS;
      cnt        <= '0;
      wait_cnt   <= '0;
      img_addr_q <= '0;
      addr_q     <= BASE_ADDR;
      data_q     <= '0;
      we_q       <= 1'b1;
      done_q     <= 1'b0;
      hold_q     <= AUTOLOAD;
    end else begin
      case (state)
        ST_FETCH: begin
          state  <= ST_SETUP;
          addr_q <= BASE_ADDR + cnt;
          data_q <= Img_data;
        end
        ST_SETUP: begin
          state    <= ST_WRITE;
          we_q     <= 1'b0;
          wait_cnt <= WAIT_INIT;
        end
        ST_WRITE: begin
          if (wait_cnt == 4'd0) begin
            state <= ST_HOLD;
            we_q  <= 1'b1;
            // Present the next ROM address early so its data is ready by the next FETCH.
            img_addr_q <= (cnt == LAST_WORD) ? 16'h0000 : cnt + 16'd1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (cnt == LAST_WORD) begin
            state  <= ST_PASS;
            done_q <= 1'b1;
            hold_q <= 1'b0;
          end else begin
            state <= ST_FETCH;
            cnt   <= cnt + 16'd1;
          end
        end
        ST_PASS: begin
          if (Load_req) begin
            state  <= ST_FETCH;
            cnt    <= '0;
            done_q <= 1'b0;
            hold_q <= 1'b1;
          end
        end
        default: state <= ST_PASS;
      endcase
    end
  end

  logic pass;
  assign pass = (state == ST_PASS);

  assign Img_addr     = img_addr_q;
  assign ADDR         = pass ? Cpu_ADDR : addr_q;
  assign Data_to_SRAM = pass ? Cpu_Data_to_SRAM : data_q;
  assign OE           = pass ? Cpu_OE : 1'b1;
  assign WE           = pass ? Cpu_WE : we_q;
  assign Cpu_hold     = hold_q;
  assign Done         = done_q;

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - self-checking bench for mem_loader
module tb_mem_loader;
  import mem_loader_pkg::*;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    logic        oe;
    logic        we;
    logic [15:0] e_a;
    logic [15:0] e_d;
    logic        e_oe;
    logic        e_we;
  } pv_t;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset_n;
  logic        Load_req;
  logic [15:0] cpu_addr, cpu_data;
  logic        cpu_oe, cpu_we;
  logic [15:0] rom [0:3];

  logic [15:0] img_addr_a, img_data_a, addr_a, dat_a;
  logic        oe_a, we_a, hold_a, done_a;
  logic [15:0] img_addr_b, img_data_b, addr_b, dat_b;
  logic        oe_b, we_b, hold_b, done_b;
  logic [15:0] img_addr_c, img_data_c, addr_c, dat_c;
  logic        oe_c, we_c, hold_c, done_c;

  logic [15:0] sram_a [0:65535];
  logic [15:0] sram_b [0:65535];

  int  n_vec = 0;
  int  n_err = 0;
  wr_t sb_q[$];

  mem_loader #(.IMG_WORDS(4), .BASE_ADDR(16'h0000), .WR_CYCLES(2), .AUTOLOAD(1'b1)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .Load_req(Load_req),
    .Img_addr(img_addr_a), .Img_data(img_data_a),
    .Cpu_ADDR(cpu_addr), .Cpu_Data_to_SRAM(cpu_data), .Cpu_OE(cpu_oe), .Cpu_WE(cpu_we),
    .ADDR(addr_a), .Data_to_SRAM(dat_a), .OE(oe_a), .WE(we_a),
    .Cpu_hold(hold_a), .Done(done_a)
  );

  mem_loader #(.IMG_WORDS(4), .BASE_ADDR(16'hFFFE), .WR_CYCLES(2), .AUTOLOAD(1'b1)) u_wrap (
    .Clk(Clk), .Reset_n(Reset_n), .Load_req(Load_req),
    .Img_addr(img_addr_b), .Img_data(img_data_b),
    .Cpu_ADDR(cpu_addr), .Cpu_Data_to_SRAM(cpu_data), .Cpu_OE(cpu_oe), .Cpu_WE(cpu_we),
    .ADDR(addr_b), .Data_to_SRAM(dat_b), .OE(oe_b), .WE(we_b),
    .Cpu_hold(hold_b), .Done(done_b)
  );

  mem_loader #(.IMG_WORDS(4), .BASE_ADDR(16'h0000), .WR_CYCLES(2), .AUTOLOAD(1'b0)) u_pass (
    .Clk(Clk), .Reset_n(Reset_n), .Load_req(Load_req),
    .Img_addr(img_addr_c), .Img_data(img_data_c),
    .Cpu_ADDR(cpu_addr), .Cpu_Data_to_SRAM(cpu_data), .Cpu_OE(cpu_oe), .Cpu_WE(cpu_we),
    .ADDR(addr_c), .Data_to_SRAM(dat_c), .OE(oe_c), .WE(we_c),
    .Cpu_hold(hold_c), .Done(done_c)
  );

  // Synchronous image ROM: data valid one cycle after the address.
  always @(posedge Clk) begin
    img_data_a <= rom[img_addr_a[1:0]];
    img_data_b <= rom[img_addr_b[1:0]];
    img_data_c <= rom[img_addr_c[1:0]];
  end

  always @(posedge Clk) begin
    if (!we_a) sram_a[addr_a] <= dat_a;
    if (!we_b) sram_b[addr_b] <= dat_b;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Write-pulse monitor for the loader writes of u_dut.
  logic        in_wr = 1'b0;
  int          lo_len = 0;
  logic [15:0] wr_addr, wr_data, prev_addr, prev_data;
  wr_t         exp_wr;

  always @(negedge Clk) begin
    if (!Reset_n) begin
      in_wr = 1'b0;
    end else begin
      if (hold_a && !we_a && !in_wr) begin
        in_wr   = 1'b1;
        lo_len  = 1;
        wr_addr = addr_a;
        wr_data = dat_a;
        check("setup_addr", prev_addr, addr_a);
        check("setup_data", prev_data, dat_a);
        check("load_oe", 16'(oe_a), 16'h1);
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got addr %h data %h, expected no write", addr_a, dat_a);
        end else begin
          exp_wr = sb_q.pop_front();
          check("write_addr", addr_a, exp_wr.addr);
          check("write_data", dat_a, exp_wr.data);
        end
      end else if (in_wr && !we_a) begin
        lo_len++;
        check("write_addr_stable", addr_a, wr_addr);
        check("write_data_stable", dat_a, wr_data);
      end else if (in_wr && we_a) begin
        in_wr = 1'b0;
        check("we_low_cycles", 16'(lo_len), 16'd2);
        check("hold_addr", addr_a, wr_addr);
        check("hold_data", dat_a, wr_data);
        check("hold_oe", 16'(oe_a), 16'h1);
      end
      prev_addr = addr_a;
      prev_data = dat_a;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_expect();
    for (int i = 0; i < 4; i++) sb_q.push_back('{addr: 16'(i), data: rom[i]});
  endtask

  // Counts edges until Done rises; an extra Load_req is pulsed at cycle ignore_at.
  task automatic run_load(input string name, input int ignore_at, input int start_cyc);
    int cyc = start_cyc;
    while (!done_a && cyc < 200) begin
      Load_req = (cyc == ignore_at);
      tick();
      cyc++;
    end
    Load_req = 1'b0;
    check({name, "_cycles"}, 16'(cyc), 16'd20);
    check({name, "_hold"}, 16'(hold_a), 16'h0);
    check({name, "_done"}, 16'(done_a), 16'h1);
  endtask

  task automatic check_sram_a(input string name);
    for (int i = 0; i < 4; i++) check(name, sram_a[i], rom[i]);
  endtask

  pv_t pv [4];

  initial begin
    pv[0] = '{16'h0030, 16'hBEEF, 1'b1, 1'b0, 16'h0030, 16'hBEEF, 1'b1, 1'b0};
    pv[1] = '{16'h0031, 16'h1234, 1'b1, 1'b0, 16'h0031, 16'h1234, 1'b1, 1'b0};
    pv[2] = '{16'h0030, 16'h0000, 1'b0, 1'b1, 16'h0030, 16'h0000, 1'b0, 1'b1};
    pv[3] = '{16'hFFFF, 16'hA5A5, 1'b1, 1'b1, 16'hFFFF, 16'hA5A5, 1'b1, 1'b1};

    rom = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    Reset_n  = 1'b0;
    Load_req = 1'b0;
    cpu_addr = 16'h1234;
    cpu_data = 16'h5678;
    cpu_oe   = 1'b1;
    cpu_we   = 1'b1;
    repeat (3) tick();

    check("rst_hold", 16'(hold_a), 16'h1);
    check("rst_done", 16'(done_a), 16'h0);
    check("rst_we", 16'(we_a), 16'h1);
    check("rst_oe", 16'(oe_a), 16'h1);
    check("rst_img_addr", img_addr_a, 16'h0000);
    check("rst_addr", addr_a, 16'h0000);
    check("rst_data", dat_a, 16'h0000);
    check("rst_wrap_addr", addr_b, 16'hFFFE);
    check("rst_noauto_hold", 16'(hold_c), 16'h0);
    check("rst_noauto_done", 16'(done_c), 16'h0);
    check("rst_noauto_addr", addr_c, 16'h1234);

    push_expect();
    @(negedge Clk);
    Reset_n = 1'b1;
    run_load("load1", -1, 0);
    check_sram_a("load1_sram");
    check("wrap_fffe", sram_b[16'hFFFE], 16'h1111);
    check("wrap_ffff", sram_b[16'hFFFF], 16'h2222);
    check("wrap_0000", sram_b[16'h0000], 16'h3333);
    check("wrap_0001", sram_b[16'h0001], 16'h4444);
    check("load1_queue_left", 16'(sb_q.size()), 16'd0);

    for (int i = 0; i < 4; i++) begin
      cpu_addr = pv[i].a;
      cpu_data = pv[i].d;
      cpu_oe   = pv[i].oe;
      cpu_we   = pv[i].we;
      #1;
      check("pass_addr", addr_a, pv[i].e_a);
      check("pass_data", dat_a, pv[i].e_d);
      check("pass_oe", 16'(oe_a), 16'(pv[i].e_oe));
      check("pass_we", 16'(we_a), 16'(pv[i].e_we));
      tick();
    end
    cpu_oe = 1'b1;
    cpu_we = 1'b1;
    tick();
    check("pass_sram_30", sram_a[16'h0030], 16'hBEEF);
    check("pass_sram_31", sram_a[16'h0031], 16'h1234);

    rom = '{16'h5555, 16'h6666, 16'h7777, 16'h8888};
    repeat (2) tick();
    push_expect();
    Load_req = 1'b1;
    tick();
    Load_req = 1'b0;
    check("reload_hold", 16'(hold_a), 16'h1);
    check("reload_done", 16'(done_a), 16'h0);
    run_load("reload", 7, 0);
    check_sram_a("reload_sram");
    check("reload_queue_left", 16'(sb_q.size()), 16'd0);

    rom = '{16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC};
    repeat (2) tick();
    push_expect();
    Load_req = 1'b1;
    tick();
    Load_req = 1'b0;
    repeat (12) tick();
    check("mid_we_low", 16'(we_a), 16'h0);
    check("mid_img_addr", img_addr_a, 16'h0002);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_we", 16'(we_a), 16'h1);
    check("async_hold", 16'(hold_a), 16'h1);
    check("async_done", 16'(done_a), 16'h0);
    check("async_img_addr", img_addr_a, 16'h0000);
    sb_q.delete();
    repeat (2) tick();
    push_expect();
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    check("restart_img_addr", img_addr_a, 16'h0000);
    check("restart_addr", addr_a, 16'h0000);
    run_load("restart", -1, 1);
    check_sram_a("restart_sram");
    check("restart_queue_left", 16'(sb_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Memory loader and SRAM port arbiter between the SLC-3 CPU and the physical SRAM. After reset (or on request), it copies a program image from a synchronous image ROM into SRAM while holding the CPU in reset. It then hands the SRAM port to the CPU as a zero-latency pass-through. This removes the manual program-entry step, and benches can start from a known memory image.

## Interface
- IMG_WORDS, 256: number of 16-bit words copied; legal range 1..65535
- BASE_ADDR, 16'h0000: SRAM address of image word 0
- WR_CYCLES, 2: cycles WE is held asserted per word; legal range 1..15
- AUTOLOAD, 1: 1 = start a load on reset release; 0 = start in pass-through
- Clk  in  1  system clock; all state updates on rising edge
- Reset_n  in  1  one clock; reset is asynchronous and active-low
- Load_req  in  1  one-cycle pulse requesting a reload
- Img_addr  out  16  image ROM word address
- Img_data  in  16  image ROM read data; valid one cycle after Img_addr
- Cpu_ADDR  in  16  CPU memory address (MAR)
- Cpu_Data_to_SRAM  in  16  CPU write data
- Cpu_OE  in  1  CPU output enable, active-low
- Cpu_WE  in  1  CPU write enable, active-low
- ADDR  out  16  SRAM address
- Data_to_SRAM  out  16  SRAM write data
- OE  out  1  SRAM output enable, active-low
- WE  out  1  SRAM write enable, active-low
- Cpu_hold  out  1  high = CPU must be held in reset; ORed into the CPU Reset
- Done  out  1  high once a load has completed; cleared when a load starts

## Operation
- FSM states:
  - FETCH: Img_addr = cnt.
  - SETUP: Img_data is captured into the data register. ADDR = BASE_ADDR + cnt. WE = 1.
  - WRITE: WE = 0 for WR_CYCLES cycles, counted by a wait counter. ADDR and data are stable.
  - HOLD: WE = 1. ADDR and data are held one more cycle.
  - PASS: hand-off to the CPU.
- Per-word transitions are FETCH → SETUP → WRITE → HOLD.
- From HOLD:
  - if cnt == IMG_WORDS-1: go to PASS and set Done = 1;
  - else: cnt++ and go to FETCH.
- OE = 1 in every load state; the loader never reads SRAM.
- PASS: ADDR, Data_to_SRAM, OE and WE are driven combinationally from the Cpu_* inputs, selected by the registered state. Cpu_hold = 0.
- Load_req while in PASS: cnt = 0, Done = 0, Cpu_hold = 1, next state FETCH. The CPU is reset in the same cycle the request is taken.
- Load_req while in any load state is ignored. A load always runs to completion.
- Address arithmetic is 16-bit, modulo 2^16. BASE_ADDR + cnt wraps past 16'hFFFF to 16'h0000.
- Cpu_* inputs are ignored outside PASS.

## Timing
- Reset values:
  - AUTOLOAD = 1: state FETCH, Cpu_hold = 1.
  - AUTOLOAD = 0: state PASS, Cpu_hold = 0.
  - Both cases: cnt = 0, Done = 0, Img_addr = 0, WE = 1, OE = 1, internal ADDR/data registers = BASE_ADDR/0.
- Per-word cost: WR_CYCLES+3 cycles. Full load: IMG_WORDS*(WR_CYCLES+3) cycles from reset release or Load_req acceptance to PASS.
- ADDR and data are stable one cycle before WE falls and one cycle after WE rises (setup/hold).
- Done and Cpu_hold change on the same edge that enters PASS. The CPU leaves reset on the next cycle.
- Reset_n asserted mid-load: immediate return to reset values. With AUTOLOAD = 1 the load restarts from word 0; no partial-state resume.
- All load-path outputs are registered. Only the PASS mux is combinational.

## Structure
- Package mem_loader_pkg holds:
  - the state enum (FETCH, SETUP, WRITE, HOLD, PASS);
  - the 16-bit word typedef;
  - a default WR_CYCLES constant.
- Single module, no sub-modules. The wait counter, word counter and FSM are inline.
- Instantiated in the top level between the CPU memory signals and the SRAM pins. Cpu_hold is ORed with the board reset into the CPU.

## Test plan
- **Basic load:** AUTOLOAD = 1, IMG_WORDS = 4, WR_CYCLES = 2, ROM = {1111,2222,3333,4444}, release Reset_n → SRAM[0..3] hold those values; PASS and Done = 1 exactly 20 cycles after release.
- **Write waveform:** for every word, WE is low for exactly 2 cycles; ADDR and data are constant from SETUP through HOLD; OE stays 1 throughout.
- **Pass-through:** in PASS, Cpu_ADDR = 16'h0030, Cpu_WE = 0, data 16'hBEEF → the same values appear on ADDR, WE and Data_to_SRAM in the same cycle, and SRAM[0x30] = 16'hBEEF.
- **Reload and ignored request:**
  - Load_req in PASS → Cpu_hold rises on the next edge, Done falls, and a full reload completes.
  - A second Load_req mid-load has no effect: total load time is unchanged.
- **Address wrap:** BASE_ADDR = 16'hFFFE, IMG_WORDS = 4 → writes land at FFFE, FFFF, 0000, 0001.
- **Reset mid-operation:** assert Reset_n low during the WRITE of word 2 → WE = 1, Cpu_hold = 1 and Done = 0 immediately (asynchronous). After release, the load restarts at word 0 with Img_addr = 0.
